// File: rtl/vga_timing_gen_pkg.sv
// Shared 640x480@60 VGA timing constants, also used by the game-side block controller.
package vga_timing_gen_pkg;

  localparam logic [9:0] H_TOTAL     = 10'd800;
  localparam logic [9:0] H_SYNC      = 10'd96;
  localparam logic [9:0] H_VIS_START = 10'd144;
  localparam logic [9:0] H_VIS_END   = 10'd783;
  localparam logic [9:0] V_TOTAL     = 10'd525;
  localparam logic [9:0] V_SYNC      = 10'd2;
  localparam logic [9:0] V_VIS_START = 10'd35;
  localparam logic [9:0] V_VIS_END   = 10'd514;

  localparam logic [9:0] BLOCK_HEIGHT = 10'd50;

  // Inclusive range test on a counter value.
  function automatic logic in_span(logic [9:0] x, logic [9:0] lo, logic [9:0] hi);
    return (x >= lo) && (x <= hi);
  endfunction

endpackage

// File: rtl/pix_en_gen.sv
// Pixel-rate strobe: one clk-wide pulse every CLK_DIV system clocks.
module pix_en_gen #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  output logic pix_en
);

  localparam int unsigned Width = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [Width-1:0] DivLast = Width'(CLK_DIV - 1);

  logic [Width-1:0] div_q, div_d;

  always_comb begin
    div_d = div_q + 1'b1;
    if (div_q == DivLast) begin
      div_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q <= '0;
    end else begin
      div_q <= div_d;
    end
  end

  assign pix_en = (div_q == DivLast);

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster counters with sync/visible decode plus frame and game-rate ticks.
module vga_timing_gen
  import vga_timing_gen_pkg::*;
#(
  parameter int unsigned CLK_DIV  = 4,
  parameter int unsigned GAME_DIV = 1
) (
  input  logic       clk,
  input  logic       rst,
  output logic       pix_en,
  output logic [9:0] hCount,
  output logic [9:0] vCount,
  output logic       hSync,
  output logic       vSync,
  output logic       bright,
  output logic       frame_tick,
  output logic       game_tick
);

  localparam logic [7:0] GameLast = 8'(GAME_DIV - 1);

  logic [9:0] h_q, h_d;
  logic [9:0] v_q, v_d;
  logic [7:0] frame_cnt_q, frame_cnt_d;
  logic       line_end;
  logic       frame_end;

  pix_en_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_pix_en_gen (
    .clk    (clk),
    .rst    (rst),
    .pix_en (pix_en)
  );

  always_comb begin
    h_d         = h_q;
    v_d         = v_q;
    frame_cnt_d = frame_cnt_q;
    line_end    = (h_q == H_TOTAL - 10'd1);
    frame_end   = line_end && (v_q == V_TOTAL - 10'd1);
    if (pix_en) begin
      if (line_end) begin
        h_d = '0;
        v_d = frame_end ? '0 : v_q + 10'd1;
      end else begin
        h_d = h_q + 10'd1;
      end
    end
    if (frame_tick) begin
      frame_cnt_d = (frame_cnt_q == GameLast) ? '0 : frame_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_q         <= '0;
      v_q         <= '0;
      frame_cnt_q <= '0;
    end else begin
      h_q         <= h_d;
      v_q         <= v_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  // Decode straight off the registered counters so syncs line up with hCount/vCount.
  assign hCount     = h_q;
  assign vCount     = v_q;
  assign hSync      = (h_q >= H_SYNC);
  assign vSync      = (v_q >= V_SYNC);
  assign bright     = in_span(h_q, H_VIS_START, H_VIS_END) &&
                      in_span(v_q, V_VIS_START, V_VIS_END);
  assign frame_tick = pix_en && frame_end;
  assign game_tick  = frame_tick && (frame_cnt_q == GameLast);

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameter: CLK_DIV, 4, system clk cycles per pixel (power of two, 2..16).
REQ-002 Parameter: GAME_DIV, 1, frames per game_tick (1..255).
REQ-003 clk  in  1  system clock (100 MHz).
REQ-004 rst  in  1  reset: asynchronous, active-high.
REQ-005 pix_en  out  1  one-clk pulse once every CLK_DIV clks; counters advance only on it.
REQ-006 hCount  out  10  horizontal pixel counter, 0..799.
REQ-007 vCount  out  10  vertical line counter, 0..524.
REQ-008 hSync  out  1  horizontal sync, active-low.
REQ-009 vSync  out  1  vertical sync, active-low.
REQ-010 bright  out  1  high inside the visible 640x480 window.
REQ-011 frame_tick  out  1  one-clk pulse at the last pixel of each frame.
REQ-012 game_tick  out  1  one-clk pulse every GAME_DIV frames; serves as the slow game-logic clock enable.

Function
REQ-013 A divider counter SHALL count 0..CLK_DIV-1 on every clk and wrap to 0; pix_en SHALL be high exactly when the divider equals CLK_DIV-1.
REQ-014 On pix_en, hCount SHALL increment; at 799 it SHALL wrap to 0 and vCount SHALL increment in the same clk.
REQ-015 On pix_en with hCount=799 and vCount=524, both counters SHALL wrap to 0 in the same clk.
REQ-016 Counters SHALL hold their value on every clk where pix_en is low.
REQ-017 hSync SHALL be 0 for hCount 0..95 and 1 otherwise; vSync SHALL be 0 for vCount 0..1 and 1 otherwise.
REQ-018 bright SHALL be 1 iff 144<=hCount<=783 and 35<=vCount<=514; all bounds are inclusive.
REQ-019 hSync, vSync and bright SHALL decode combinationally from the registered counters, with zero cycles of latency relative to hCount/vCount.
REQ-020 frame_tick SHALL be 1 for exactly the clk where pix_en=1, hCount=799 and vCount=524.
REQ-021 An 8-bit frame counter SHALL increment on frame_tick and wrap from GAME_DIV-1 to 0.
REQ-022 game_tick SHALL assert coincident with the frame_tick on which the frame counter equals GAME_DIV-1.
REQ-023 With GAME_DIV=1, game_tick SHALL equal frame_tick.
REQ-024 Frame period SHALL be exactly 800*525*CLK_DIV clks (1,680,000 clks at CLK_DIV=4).

Reset
REQ-025 On rst assertion, and regardless of clk, the block SHALL set the divider, hCount, vCount and frame counter to 0. Outputs in reset: pix_en=0, hSync=0, vSync=0, bright=0, frame_tick=0, game_tick=0.
REQ-026 Reset mid-frame SHALL abandon the frame with no tick pulse; counting SHALL restart from 0,0.
REQ-027 After rst deasserts, the first pix_en SHALL occur on the CLK_DIV-th rising clk edge.

Structure
REQ-028 A shared package SHALL hold the timing constants H_TOTAL=800, H_SYNC=96, H_VIS_START=144, H_VIS_END=783, V_TOTAL=525, V_SYNC=2, V_VIS_START=35, V_VIS_END=514 and the block height of 50. block_controller SHALL import the same package.
REQ-029 The divider SHALL be one sub-module, pix_en_gen (parameter CLK_DIV; ports clk, rst, pix_en). The counters and decode SHALL stay in vga_timing_gen.

Verification
REQ-030 Reset, then release with CLK_DIV=4 -> pix_en high on clks 4, 8, 12, ...; hCount=1 after clk 4; hSync=0 and bright=0 throughout the first 96 pixels.
REQ-031 Run to hCount=143/144 on vCount=35 -> bright 0 at 143 and 1 at 144; bright 1 at 783 and 0 at 784; same check on vCount 34/35 and 514/515.
REQ-032 Run a full frame -> exactly one frame_tick at hCount=799, vCount=524; next pix_en gives 0,0; frame length 1,680,000 clks.
REQ-033 GAME_DIV=3, run 7 frames -> game_tick on frame_ticks 3 and 6 only.
REQ-034 Assert rst at hCount=400, vCount=200, mid-divider -> all outputs 0 immediately (asynchronous); no tick pulses; restart matches REQ-030.
REQ-035 Line-count check -> vSync low for exactly 2*800 pixels per frame; hSync low for exactly 96 pixels per line.
